// File: rtl/hh_step_sched_if.sv
// hh_step_sched_if: rate fetch, shared multiplier and commit handshakes of the HH step scheduler
interface hh_step_sched_if #(parameter int W = 14);
  logic                rate_req;
  logic                rate_valid;
  logic                mul_req;
  logic [3:0]          mul_op;
  logic                mul_ack;
  logic                commit;
  logic signed [W-1:0] v_now;
  modport master (output rate_req, mul_req, mul_op, commit, input rate_valid, mul_ack, v_now);
  modport slave (input rate_req, mul_req, mul_op, commit, output rate_valid, mul_ack, v_now);
endinterface

// File: rtl/hh_step_sched.sv
// hh_step_sched: HH integration step scheduler (tick, rate fetch, micro-op sequencing, commit, spike); HH_REFRACTORY_EN adds refractory spike masking
module hh_step_sched #(
  parameter int                  W            = 14,
  parameter int                  STEP_DIV     = 16,
  parameter int                  NUM_OPS      = 12,
  parameter logic signed [W-1:0] SPIKE_TH     = '0,
  parameter int                  REFRAC_STEPS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  hh_step_sched_if.master      bus,
  output logic                 spike,
  output logic [15:0]          step_cnt,
  output logic                 busy,
  output logic                 overrun
);
  localparam int TW = $clog2(STEP_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(STEP_DIV - 1);
  localparam logic [3:0] OP_LAST = 4'(NUM_OPS - 1);
  localparam logic signed [W-1:0] V_REST = -(W'(65) <<< 5);
  typedef enum logic [2:0] {IDLE, RATES, MULS, COMMIT, SPK} state_t;
  state_t state, state_nx;
  logic [TW-1:0] tick_cnt;
  logic [3:0] op;
  logic signed [W-1:0] v_prev;
  logic tick, refr_ok;
  assign tick = en && tick_cnt == TICK_LAST;
`ifdef HH_REFRACTORY_EN
  localparam int RW = $clog2(REFRAC_STEPS + 1);
  logic [RW-1:0] refr;
  assign refr_ok = refr == '0;
  // refractory window: armed by a spike pulse, counted down by commits
  always_ff @(posedge clk)
    if (rst) refr <= '0;
    else if (spike) refr <= RW'(REFRAC_STEPS);
    else if (state == COMMIT && !refr_ok) refr <= refr - 1'b1;
`else
  assign refr_ok = 1'b1;
`endif
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // step sequencing
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = tick ? RATES : IDLE;
      RATES:   state_nx = bus.rate_valid ? MULS : RATES;
      MULS:    state_nx = (bus.mul_ack && op == OP_LAST) ? COMMIT : MULS;
      COMMIT:  state_nx = SPK;
      default: state_nx = IDLE;
    endcase
  end
  // tick divider, op index, counters and registered outputs
  always_ff @(posedge clk)
    if (rst) begin
      tick_cnt     <= '0;
      op           <= '0;
      v_prev       <= V_REST;
      spike        <= 1'b0;
      step_cnt     <= '0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      bus.rate_req <= 1'b0;
      bus.mul_req  <= 1'b0;
      bus.commit   <= 1'b0;
    end else begin
      if (en) tick_cnt <= tick_cnt == TICK_LAST ? '0 : tick_cnt + 1'b1;
      if (state == MULS && bus.mul_ack) op <= op == OP_LAST ? '0 : op + 1'b1;
      if (state == SPK) v_prev <= bus.v_now;
      spike        <= state == SPK && bus.v_now >= SPIKE_TH && v_prev < SPIKE_TH && refr_ok;
      step_cnt     <= step_cnt + 16'(state == COMMIT);
      overrun      <= overrun | (tick && state != IDLE);
      busy         <= state_nx != IDLE;
      bus.rate_req <= state_nx == RATES;
      bus.mul_req  <= state_nx == MULS;
      bus.commit   <= state_nx == COMMIT;
    end
  assign bus.mul_op = op;
endmodule

// File: tb/tb_hh_step_sched.sv
// tb_hh_step_sched: directed checks of tick timing, handshakes, overrun, spike detection and reset abort
module tb_hh_step_sched;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic spike, busy, overrun;
  logic [15:0] step_cnt;
  int n_cmp = 0, n_err = 0;
  hh_step_sched_if #(.W(14)) bus();
  hh_step_sched dut (.clk(clk), .rst(rst), .en(en), .bus(bus), .spike(spike), .step_cnt(step_cnt), .busy(busy), .overrun(overrun));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wait_rate(output int n);
    n = 0;
    while (!bus.rate_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rate_req) chk("rate_timeout", 0, 1);
  endtask
  task automatic run_step(input logic signed [13:0] v, input int exp_spk, input string tag);
    int n, c, s;
    en = 1'b1;
    wait_rate(n);
    en = 1'b0;
    bus.v_now = v;
    c = 0;
    s = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.commit) c++;
      if (spike) s++;
    end
    chk({tag, "_commits"}, c, 1);
    chk({tag, "_spike"}, s, exp_spk);
  endtask
  initial begin
    int n, e, c, rq, k;
    bit a;
    bus.rate_valid = 1'b0;
    bus.mul_ack = 1'b0;
    bus.v_now = -14'sd2080;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {bus.rate_req, bus.mul_req, bus.commit, spike, overrun}, 0);
    chk("rst_op", bus.mul_op, 0);
    chk("rst_steps", step_cnt, 0);
    rst = 1'b0;
    en = 1'b1;
    bus.rate_valid = 1'b1;
    bus.mul_ack = 1'b1;
    wait_rate(n);
    chk("tick_lat", n, 16);
    chk("rates_busy", busy, 1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("op_seq", {bus.mul_req, bus.mul_op}, {1'b1, 4'(i)});
    end
    @(negedge clk);
    chk("commit_at", bus.commit, 1);
    @(negedge clk);
    chk("commit_pulse", bus.commit, 0);
    chk("step1", step_cnt, 1);
    chk("spk_busy", busy, 1);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("no_spike_rest", spike, 0);
    wait_rate(n);
    en = 1'b0;
    bus.mul_ack = 1'b0;
    e = 0;
    c = 0;
    rq = 0;
    a = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (bus.mul_req) begin
        chk("op_hold", bus.mul_op, e);
        a = !a;
        bus.mul_ack = a;
        if (a) e++;
      end else bus.mul_ack = 1'b0;
      if (bus.commit) c++;
      if (bus.rate_req) rq++;
    end
    chk("ops_done", e, 12);
    chk("toggle_commits", c, 1);
    chk("step2", step_cnt, 2);
    chk("no_overrun", overrun, 0);
    chk("frozen_tick", rq, 0);
    bus.rate_valid = 1'b0;
    bus.mul_ack = 1'b0;
    en = 1'b1;
    wait_rate(n);
    chk("resume_lat", n, 16);
    repeat (20) @(negedge clk);
    chk("rates_hold", bus.rate_req, 1);
    chk("overrun_set", overrun, 1);
    bus.rate_valid = 1'b1;
    bus.mul_ack = 1'b1;
    en = 1'b0;
    c = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.commit) c++;
    end
    chk("stall_commits", c, 1);
    chk("step3", step_cnt, 3);
    chk("overrun_sticky", overrun, 1);
    run_step(-14'sd2080, 0, "v_m65");
    run_step(-14'sd320, 0, "v_m10");
    run_step(14'sd160, 1, "v_p5");
    run_step(14'sd640, 0, "v_p20");
    run_step(-14'sd2240, 0, "v_m70");
`ifdef HH_REFRACTORY_EN
    run_step(14'sd96, 0, "v_p3");
`else
    run_step(14'sd96, 1, "v_p3");
`endif
    chk("step9", step_cnt, 9);
    en = 1'b1;
    wait_rate(n);
    en = 1'b0;
    k = 0;
    while (!(bus.mul_req && bus.mul_op == 4'd5) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("reach_op5", bus.mul_op, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_outs", {bus.rate_req, bus.mul_req, bus.commit, spike, overrun}, 0);
    chk("abort_op", bus.mul_op, 0);
    c = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.commit) c++;
    end
    chk("abort_commits", c, 0);
    run_step(14'sd160, 1, "vprev_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
